// File: rtl/bit_serializer_if.sv
// Load handshake and serial-stream signals of bit_serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             bit_strobe;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_data,
        input  load_ready, ser_out, ser_valid, bit_strobe, busy, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, ser_out, ser_valid, bit_strobe, busy, done
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial pattern source: one bit per DIV cycles, done pulse per word.
// Define SERIALIZER_BACK2BACK_EN to let the DONE cycle accept the next word.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    bit_serializer_if.slave  lif
);
    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [DW-1:0]    div_cnt, div_cnt_n;
    logic [WIDTH-1:0] shreg_adv;

    // Shift toward the output end with zero fill
    always_comb begin
        if (MSB_FIRST != 0) shreg_adv = {shreg[WIDTH-2:0], 1'b0};
        else                shreg_adv = {1'b0, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            div_cnt <= div_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        case (state)
            IDLE: begin
                if (lif.load_valid) begin
                    state_n   = SHIFT;
                    shreg_n   = lif.load_data;
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    // Counters hold at their terminal values on the last bit
                    if (bit_cnt == BIT_LAST) begin
                        state_n = DONE;
                    end else begin
                        shreg_n   = shreg_adv;
                        bit_cnt_n = bit_cnt + 1'b1;
                        div_cnt_n = '0;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            DONE: begin
`ifdef SERIALIZER_BACK2BACK_EN
                if (lif.load_valid) begin
                    state_n   = SHIFT;
                    shreg_n   = lif.load_data;
                    bit_cnt_n = '0;
                    div_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Every output is a decode of registered state, never of inputs
    assign lif.ser_valid  = (state == SHIFT);
    assign lif.busy       = (state == SHIFT);
    assign lif.done       = (state == DONE);
    assign lif.ser_out    = (state == SHIFT) && shreg[(MSB_FIRST != 0) ? WIDTH-1 : 0];
    assign lif.bit_strobe = (state == SHIFT) && (div_cnt == '0);
`ifdef SERIALIZER_BACK2BACK_EN
    assign lif.load_ready = (state == IDLE) || (state == DONE);
`else
    assign lif.load_ready = (state == IDLE);
`endif
endmodule
